// File: rtl/mips_icache_if.sv
//------------------------------------------------------------------------------
// Module   : mips_icache_if
// Brief    : IF-fetch and line-fill bus bundle for mips_icache. The "slave"
//            modport is the cache's view: it responds to IF fetches and
//            drives the memory line-read request. The "master" modport is the
//            opposite side, meaning IF plus instruction memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mips_icache_if;
  // IF fetch side
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  // memory line-fill side
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mips_icache.sv
//------------------------------------------------------------------------------
// Module   : mips_icache
// Brief    : Direct-mapped, read-only instruction cache with 4-word lines.
//            Hits are returned combinationally. A miss stalls IF and fetches
//            the line over a mem_ready handshake.
//            Optional macro ICACHE_CRITICAL_WORD_EN forwards the requested
//            word straight from mem_rdata in the fill cycle.
//            TAG_W must equal 28 - LINE_IDX_W.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_icache #(
  parameter int LINE_IDX_W = 3,
  parameter int TAG_W      = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  mips_icache_if.slave bus
);

  localparam int NUM_LINES = 2 ** LINE_IDX_W;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [27:0]           miss_addr_q, miss_addr_d;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [127:0]          data_q [NUM_LINES];

  logic [LINE_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [1:0]            w_word;
  logic [127:0]          w_line;
  logic                  w_hit;
  logic                  w_fill;
  logic [LINE_IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_unused;

  assign w_idx      = bus.proc_addr[LINE_IDX_W+1:2];
  assign w_tag      = bus.proc_addr[29:LINE_IDX_W+2];
  assign w_word     = bus.proc_addr[1:0];
  assign w_line     = data_q[w_idx];
  assign w_hit      = bus.proc_read && (state_q == S_IDLE) && valid_q[w_idx]
                      && (tag_q[w_idx] == w_tag);
  assign w_fill     = (state_q == S_FETCH) && bus.mem_ready;
  assign w_fill_idx = miss_addr_q[LINE_IDX_W-1:0];
  assign w_fill_tag = miss_addr_q[27:LINE_IDX_W];

  // Writes are never issued by IF; the cache is read-only.
  assign w_unused      = ^{bus.proc_write, bus.proc_wdata};
  assign bus.mem_write = 1'b0;
  assign bus.mem_wdata = '0;
  // Request and address come straight from state so they hold until mem_ready.
  assign bus.mem_read  = (state_q == S_FETCH);
  assign bus.mem_addr  = miss_addr_q;

  // Next-state, miss capture and IF response (hit data or stall).
  always_comb begin
    state_d        = state_q;
    miss_addr_d    = miss_addr_q;
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.proc_read) begin
          if (w_hit) begin
            bus.proc_rdata = w_line[{w_word, 5'b00000} +: 32];
          end else begin
            bus.proc_stall = 1'b1;
            miss_addr_d    = bus.proc_addr[29:2];
            state_d        = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        // The fill always completes to miss_addr, even if IF has redirected.
        bus.proc_stall = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_IDLE;
`ifdef ICACHE_CRITICAL_WORD_EN
          if (bus.proc_read && (bus.proc_addr[29:2] == miss_addr_q)) begin
            bus.proc_stall = 1'b0;
            bus.proc_rdata = bus.mem_rdata[{w_word, 5'b00000} +: 32];
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and valid bits; reset clears them at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (w_fill) begin
        valid_q[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are only ever qualified by valid, so they are not reset.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      tag_q[w_fill_idx]  <= w_fill_tag;
      data_q[w_fill_idx] <= bus.mem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_icache.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_icache
// Brief    : Self-checking bench for mips_icache. A line-addressed model of the
//            cache contents predicts every IF/memory output each cycle.
//            Directed scenarios pin literal values; random traffic follows.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_icache;

  localparam int NLINES = 8;

`ifdef ICACHE_CRITICAL_WORD_EN
  localparam int MISS_CYC = 3;
`else
  localparam int MISS_CYC = 4;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mips_icache_if bus ();

  mips_icache #(.LINE_IDX_W(3), .TAG_W(25)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] d, input logic [1:0] w);
    return d[w*32 +: 32];
  endfunction

  // Memory content: word k of line la holds (4*la + k + 1).
  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [31:0] b;
    b = {2'b00, la, 2'b00} + 32'd1;
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // ---------------- memory responder ----------------
  int fixed_l;
  bit rand_data;
  bit spur;
  bit force_ready;
  int cnt;
  int cur_l;

  always @(posedge clk) begin
    #1;
    if (bus.mem_read) begin
      if (cnt == 0) cur_l = (fixed_l != 0) ? fixed_l : int'($urandom_range(1, 4));
      cnt++;
      if (cnt == cur_l) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rand_data ? {$urandom, $urandom, $urandom, $urandom}
                                  : mem_line(bus.mem_addr);
        cnt = 0;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      cnt = 0;
      bus.mem_ready = force_ready || (spur && ($urandom_range(0, 9) == 0));
      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit           m_valid [NLINES];
  logic [27:0]  m_line  [NLINES];
  logic [127:0] m_data  [NLINES];
  bit           m_fetch;
  logic [27:0]  m_miss;

  always @(negedge clk) begin
    logic [27:0] la;
    int          idx;
    logic [1:0]  w;
    bit          hit;
    logic        e_st;
    logic [31:0] e_rd;
    if (!rst_n) begin
      m_fetch = 1'b0;
      m_miss  = '0;
      for (int i = 0; i < NLINES; i++) m_valid[i] = 1'b0;
      chk("rst_mem_read", bus.mem_read, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 28'h0);
      chk("rst_rdata", bus.proc_rdata, 32'h0);
      if (!bus.proc_read) chk("rst_stall", bus.proc_stall, 1'b0);
    end else begin
      la   = bus.proc_addr[29:2];
      idx  = int'(la) % NLINES;
      w    = bus.proc_addr[1:0];
      hit  = 1'b0;
      e_st = 1'b0;
      e_rd = '0;
      if (!m_fetch) begin
        hit = bus.proc_read && m_valid[idx] && (m_line[idx] == la);
        if (hit) e_rd = word_of(m_data[idx], w);
        else if (bus.proc_read) e_st = 1'b1;
      end else begin
        e_st = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_EN
        if (bus.mem_ready && bus.proc_read && (la == m_miss)) begin
          e_st = 1'b0;
          e_rd = word_of(bus.mem_rdata, w);
        end
`endif
        chk("mem_addr", bus.mem_addr, m_miss);
      end
      chk("proc_stall", bus.proc_stall, e_st);
      chk("proc_rdata", bus.proc_rdata, e_rd);
      chk("mem_read", bus.mem_read, m_fetch);
      chk("mem_write", bus.mem_write, 1'b0);
      chk("mem_wdata", bus.mem_wdata, 128'h0);
      // advance the model to what the next clock edge produces
      if (!m_fetch) begin
        if (bus.proc_read && !hit) begin
          m_fetch = 1'b1;
          m_miss  = la;
        end
      end else if (bus.mem_ready) begin
        idx          = int'(m_miss) % NLINES;
        m_valid[idx] = 1'b1;
        m_line[idx]  = m_miss;
        m_data[idx]  = bus.mem_rdata;
        m_fetch      = 1'b0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Issue a read and count stalled cycles until it is served.
  task automatic fetch_and_count(input logic [29:0] a, input int exp_cyc,
                                 input logic [31:0] exp_data, input logic [27:0] exp_maddr);
    int          n;
    logic [27:0] seen;
    seen = '1;
    n    = 0;
    @(posedge clk); #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = a;
    forever begin
      @(negedge clk);
      if (bus.mem_read) seen = bus.mem_addr;
      if (!bus.proc_stall) break;
      n++;
      if (n > 20) begin
        chk("stall_timeout", 1'b1, 1'b0);
        break;
      end
    end
    chk("miss_stall_cycles", n, exp_cyc);
    chk("miss_rdata", bus.proc_rdata, exp_data);
    chk("miss_mem_addr", seen, exp_maddr);
  endtask

  task automatic hit_check(input logic [29:0] a, input logic [31:0] exp_data);
    @(posedge clk); #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = a;
    @(negedge clk);
    chk("hit_stall", bus.proc_stall, 1'b0);
    chk("hit_rdata", bus.proc_rdata, exp_data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    fixed_l = 3;
    rand_data = 1'b0;
    spur = 1'b0;
    force_ready = 1'b0;
    cnt = 0;
    cur_l = 1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_stall", bus.proc_stall, 1'b0);
    chk("reset_mem_read", bus.mem_read, 1'b0);
    chk("reset_rdata", bus.proc_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // cold miss on line 0, then hits on the remaining words
    fetch_and_count(30'h0, MISS_CYC, 32'h1, 28'h0);
    hit_check(30'h1, 32'h2);
    hit_check(30'h2, 32'h3);
    hit_check(30'h3, 32'h4);

    // conflict on index 0
    fetch_and_count(30'h20, MISS_CYC, 32'h21, 28'h8);
    fetch_and_count(30'h0, MISS_CYC, 32'h1, 28'h0);

    // redirect mid-fetch: cache addr 4 first
    fetch_and_count(30'h4, MISS_CYC, 32'h5, 28'h1);
    @(posedge clk); #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h40;
    @(negedge clk);
    chk("redir_miss_stall", bus.proc_stall, 1'b1);
    @(posedge clk); #1;
    bus.proc_read = 1'b0;
    bus.proc_addr = 30'h4;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.mem_read) break;
      chk("redir_mem_addr", bus.mem_addr, 28'h10);
      n++;
      if (n > 20) begin
        chk("redir_timeout", 1'b1, 1'b0);
        break;
      end
    end
    chk("redir_idle_stall", bus.proc_stall, 1'b0);
    chk("redir_idle_rdata", bus.proc_rdata, 32'h0);
    hit_check(30'h4, 32'h5);
    hit_check(30'h40, 32'h41);

    // asynchronous reset in the middle of a fetch
    @(posedge clk); #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h60;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    bus.proc_read = 1'b0;
    #1;
    chk("async_rst_mem_read", bus.mem_read, 1'b0);
    chk("async_rst_mem_addr", bus.mem_addr, 28'h0);
    chk("async_rst_stall", bus.proc_stall, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_and_count(30'h4, MISS_CYC, 32'h5, 28'h1);

    // idle with write asserted and a stray mem_ready
    @(posedge clk); #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b1;
    bus.proc_wdata = 32'hDEADBEEF;
    force_ready    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("write_idle_stall", bus.proc_stall, 1'b0);
      chk("write_idle_mem_read", bus.mem_read, 1'b0);
    end
    @(posedge clk); #1;
    force_ready    = 1'b0;
    bus.proc_write = 1'b0;
    hit_check(30'h4, 32'h5);

    // miss on a non-zero word of an invalid line
    fetch_and_count(30'h2, MISS_CYC, 32'h3, 28'h0);

    // randomized traffic
    fixed_l   = 0;
    rand_data = 1'b1;
    spur      = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.proc_read  = ($urandom_range(0, 3) != 0);
      bus.proc_write = $urandom_range(0, 1) == 1;
      bus.proc_wdata = $urandom;
      if ($urandom_range(0, 7) == 0) bus.proc_addr = 30'($urandom);
      else bus.proc_addr = 30'($urandom_range(0, 127));
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_icache.md
Name: mips_icache

Overview:
- Direct-mapped, read-only instruction cache.
- Sits between the IF stage and instruction memory, and is the responder end of the IF fetch interface. IF drives read, write, addr and wdata; this block returns stall and rdata.
- Serves hits combinationally in the same cycle.
- On a miss, raises stall and fetches a 4-word line from memory over a ready-handshake bus.

Parameters:
- LINE_IDX_W, 3, index bits. Line count is 2**LINE_IDX_W.
- TAG_W, 25, tag bits. Must equal 28-LINE_IDX_W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- proc_read  input  1  fetch request from IF.
- proc_write  input  1  write request. Tied low by IF; ignored.
- proc_addr  input  30  word address. [29:2] is the line address, [1:0] selects the word.
- proc_wdata  input  32  unused.
- proc_stall  output  1  high while the request cannot be served this cycle.
- proc_rdata  output  32  instruction word.
- mem_read  output  1  line read request to memory.
- mem_write  output  1  constant 0.
- mem_addr  output  28  line address of the outstanding fetch.
- mem_wdata  output  128  constant 0.
- mem_rdata  input  128  line data; word k = bits [32k+31:32k].
- mem_ready  input  1  one-cycle pulse; mem_rdata is valid in that cycle.

Behaviour:
- Storage per line: valid bit, TAG_W-bit tag, 128-bit data.
  - index = proc_addr[LINE_IDX_W+1:2]
  - tag = proc_addr[29:LINE_IDX_W+2]
- hit = proc_read & state==S_IDLE & valid[index] & tag match.
- State machine, S_IDLE and S_FETCH:
  - S_IDLE, hit:
    - proc_stall=0.
    - proc_rdata = selected word of the indexed line.
    - Zero added latency.
  - S_IDLE, proc_read=1 and miss:
    - proc_stall=1 (combinational).
    - Latch miss_addr=proc_addr[29:2].
    - Next state S_FETCH.
  - S_IDLE, proc_read=0: proc_stall=0, proc_rdata=0, no memory activity.
  - S_FETCH:
    - mem_read=1 and mem_addr=miss_addr, both held stable until mem_ready.
    - proc_stall=1 and proc_rdata=0 in every cycle.
  - S_FETCH, mem_ready=1:
    - Write mem_rdata into line miss_addr[LINE_IDX_W-1:0].
    - Set its tag and set valid.
    - Next state S_IDLE.
    - mem_read is deasserted from the following cycle.
- Miss timing: with memory latency L cycles (mem_ready in the L-th S_FETCH cycle), the stall lasts L+1 cycles. The request is served as a hit in the cycle after mem_ready.
- Request changes during S_FETCH:
  - If proc_addr changes or proc_read drops (the IF branch-redirect case), the fill still completes to miss_addr.
  - The new request is re-evaluated in S_IDLE; no fetch is aborted.
- mem_ready while in S_IDLE: ignored.
- Conflict: a fill to the same index overwrites the line unconditionally.
- proc_write=1: no state change; treated as proc_read for stall purposes only if proc_read=1.
- Reset, asynchronous and valid at any time including mid-fetch:
  - All valid bits=0; state=S_IDLE; miss_addr=0.
  - Outputs immediately: mem_read=0, mem_addr=0, proc_stall=0 (when proc_read=0), proc_rdata=0.
  - Tag and data arrays are not reset.
- No X propagation: proc_rdata=0 whenever the request is not a hit, except as described in Optional Feature.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_EN.
- Defined:
  - In the S_FETCH cycle with mem_ready=1, if proc_read=1 and proc_addr[29:2]==miss_addr, then proc_stall=0 and proc_rdata=mem_rdata word proc_addr[1:0].
  - The line is still written.
  - Miss stall drops from L+1 to L cycles.
- Not defined: proc_stall stays 1 through the mem_ready cycle, as described in Behaviour.

Test Plan:
- Reset, then proc_read=1, proc_addr=0, memory L=3 with line 0 = {32'h4,32'h3,32'h2,32'h1} (word 3..0) -> proc_stall=1 for 4 cycles, mem_addr=0 during S_FETCH, then proc_rdata=32'h1 with stall=0. Addr 1,2,3 then hit with no stall -> 32'h2, 32'h3, 32'h4.
- Conflict, after line 0 is filled: proc_addr=30'h20 (same index 0, tag 1) -> miss, mem_addr=28'h8, refill. Then addr 0 -> miss again.
- Redirect mid-fetch: miss on addr 30'h40, and at S_FETCH cycle 1 change addr to 30'h4 (already cached) with proc_read=0 -> mem_addr stays 28'h10 until mem_ready. The next cycle in S_IDLE, addr 30'h4 hits.
- Async reset mid-fetch: rst_n=0 in the middle of S_FETCH -> mem_read=0 immediately. After release, the previously filled address misses (valid cleared).
- Idle and write: proc_read=0, proc_write=1, mem_ready pulsed -> proc_stall=0, mem_read=0, cache contents unchanged.
- With ICACHE_CRITICAL_WORD_EN and L=3, a miss on addr 30'h2 -> proc_stall=1 for exactly 3 cycles, and proc_rdata=word 2 in the mem_ready cycle.
